hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, busy cycles for mult/multu.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, busy cycles for div/divu.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port IR_D, input, 32, instruction currently in decode.
REQ-006 SHALL have port flush, input, 1, exception/eret flush; the D instruction does not advance.
REQ-007 SHALL have port stall, output, 1, hold PC and the D register, and insert a bubble into E.
REQ-008 SHALL have port Forward_RS_D, output, 3, D-stage rs forward select (0 GRF, 1 ALUOUT_M, 2 PC8_M, 3 XALUOUT_M).
REQ-009 SHALL have port Forward_RT_D, output, 3, D-stage rt forward select (same encoding).
REQ-010 SHALL have port Forward_RS_E, output, 3, E-stage rs select (0 pipeline reg, 1 ALUOUT_M, 2 PC8_M, 3 XALUOUT_M, 4 Wdata).
REQ-011 SHALL have port Forward_RT_E, output, 3, E-stage rt select (same encoding as REQ-010).
REQ-012 SHALL have port md_busy, output, 1, mult/div unit busy.

Function
REQ-013 SHALL classify IR_D into rs, rt, dst, src class, Tuse_rs, Tuse_rt and md flags:
- src class: ALU, LOAD, PC8, XALU (mfhi/mflo).
- dst: rd, rt or 31; 0 when the instruction writes no register.
- Tuse = 0 for branch/jr rs, 1 for ALU/MD operands, 2 for store rt; 3 when the operand is unused.
REQ-014 SHALL assign Tnew at E entry: ALU 1, XALU 1, PC8 1, LOAD 2.
REQ-015 SHALL hold shadow stage registers E{dst,src,tnew,rs,rt} and M{dst,src,tnew}:
- M <= E each cycle, with tnew decremented and saturating at 0.
- E <= decoded D, or a bubble (all fields 0) when stall or flush is high.
REQ-016 SHALL assert stall combinationally for data hazards, for operand r nonzero, when either holds:
- E.dst==r and Tuse_r < E.tnew;
- M.dst==r and Tuse_r < M.tnew.
REQ-017 SHALL also assert stall when IR_D is any MD instruction (mult*, div*, mfhi, mflo, mthi, mtlo) and either md_busy=1 or E holds a mult/div start.
REQ-018 SHALL drive Forward_*_D from M.src code when M.dst==r, r!=0 and M.tnew==0; otherwise 0. W-stage results SHALL reach D via the GRF internal write-through bypass, not through this block.
REQ-019 SHALL drive Forward_*_E from M.src code when M.dst==E.r, E.r!=0 and M.tnew==0; else 4 when W.dst==E.r and E.r!=0; else 0. M SHALL take priority over W.
REQ-020 SHALL hold W.dst (1 register) as W <= M.dst.
REQ-021 SHALL load the md counter with MULT_CYCLES or DIV_CYCLES when a mult/div enters E (not a bubble); the counter SHALL decrement to 0 each cycle and md_busy = (counter != 0).
REQ-022 SHALL leave the md counter unaffected by flush; an operation already in E runs to completion.
REQ-023 SHALL give flush priority over stall: E becomes a bubble and stall has no additional effect.

Reset
REQ-024 SHALL, on reset, clear all shadow registers and the md counter to 0.
REQ-025 SHALL, during reset, force stall to 0 and all Forward_* outputs to 0; outputs SHALL be derived from cleared state from the cycle after reset.

Structure
REQ-026 SHALL take opcode/funct constants, src class encoding, forward select codes and the Tuse/Tnew constants from shared package mips_pkg.
REQ-027 SHALL place the combinational D-stage classifier in sub-module hazard_decode; hazard_ctrl holds the sequential state and the compare logic.

Verification
REQ-028 SHALL check: lw $1,0($0) then D=beq $1,$2 -> stall=1 for 2 cycles, then Forward_RS_D=0 (value via GRF bypass).
REQ-029 SHALL check: addu $3,$1,$2 then D=jr $3 -> stall=1 for 1 cycle, then Forward_RS_D=1.
REQ-030 SHALL check: jal at M with D=jr $31 -> stall=0 and Forward_RS_D=2.
REQ-031 SHALL check: div enters E, then D=mflo -> stall=1 and md_busy=1 for 10 cycles; stall=0 on the cycle md_busy falls.
REQ-032 SHALL check: addu $0,... followed by a $0 reader -> stall=0 and all forwards 0.
REQ-033 SHALL check: flush with a load in D -> E bubble next cycle; reset mid-mult -> md_busy=0 the cycle after reset.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS decode constants, producer classes and forward-select codes
// used by the hazard unit and the datapath muxes it steers.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_BLEZ  = 6'h06;
    localparam logic [5:0] OP_BGTZ  = 6'h07;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_SLTIU = 6'h0b;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_XORI  = 6'h0e;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_SLLV  = 6'h04;
    localparam logic [5:0] FN_SRLV  = 6'h06;
    localparam logic [5:0] FN_SRAV  = 6'h07;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_JALR  = 6'h09;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1a;
    localparam logic [5:0] FN_DIVU  = 6'h1b;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2a;
    localparam logic [5:0] FN_SLTU  = 6'h2b;

    typedef enum logic [1:0] {
        SRC_ALU  = 2'd0,
        SRC_LOAD = 2'd1,
        SRC_PC8  = 2'd2,
        SRC_XALU = 2'd3
    } src_e;

    localparam logic [2:0] FWD_NONE      = 3'd0;
    localparam logic [2:0] FWD_ALUOUT_M  = 3'd1;
    localparam logic [2:0] FWD_PC8_M     = 3'd2;
    localparam logic [2:0] FWD_XALUOUT_M = 3'd3;
    localparam logic [2:0] FWD_WDATA     = 3'd4;

    localparam logic [1:0] TUSE_BR    = 2'd0;
    localparam logic [1:0] TUSE_ALU   = 2'd1;
    localparam logic [1:0] TUSE_STORE = 2'd2;
    localparam logic [1:0] TUSE_NONE  = 2'd3;

    localparam logic [1:0] TNEW_ALU  = 2'd1;
    localparam logic [1:0] TNEW_XALU = 2'd1;
    localparam logic [1:0] TNEW_PC8  = 2'd1;
    localparam logic [1:0] TNEW_LOAD = 2'd2;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] dst;
        src_e       src;
        logic [1:0] tuse_rs;
        logic [1:0] tuse_rt;
        logic       md;
        logic       md_start;
        logic       md_div;
    } dec_t;

    function automatic logic [1:0] tnew_of(input src_e s);
        case (s)
            SRC_LOAD: tnew_of = TNEW_LOAD;
            SRC_PC8:  tnew_of = TNEW_PC8;
            SRC_XALU: tnew_of = TNEW_XALU;
            default:  tnew_of = TNEW_ALU;
        endcase
    endfunction

    // A load never reaches M with tnew 0, so it has no M-stage forward code.
    function automatic logic [2:0] fwd_of(input src_e s);
        case (s)
            SRC_ALU:  fwd_of = FWD_ALUOUT_M;
            SRC_PC8:  fwd_of = FWD_PC8_M;
            SRC_XALU: fwd_of = FWD_XALUOUT_M;
            default:  fwd_of = FWD_NONE;
        endcase
    endfunction

endpackage

// File: rtl/hazard_decode.sv
// D-stage classifier: extracts operand/destination registers, producer class,
// operand use times and mult/div flags from the instruction word.
module hazard_decode
    import mips_pkg::*;
(
    input  logic [31:0] ir,
    output dec_t        dec
);

    logic [5:0] op;
    logic [5:0] fn;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       unused_shamt;

    assign op           = ir[31:26];
    assign rs           = ir[25:21];
    assign rt           = ir[20:16];
    assign rd           = ir[15:11];
    assign fn           = ir[5:0];
    assign unused_shamt = ^ir[10:6];

    always_comb begin
        dec         = '0;
        dec.rs      = rs;
        dec.rt      = rt;
        dec.src     = SRC_ALU;
        dec.tuse_rs = TUSE_NONE;
        dec.tuse_rt = TUSE_NONE;
        case (op)
            OP_RTYPE: begin
                case (fn)
                    FN_SLL, FN_SRL, FN_SRA: begin
                        dec.dst     = rd;
                        dec.tuse_rt = TUSE_ALU;
                    end
                    FN_SLLV, FN_SRLV, FN_SRAV, FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
                    FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU: begin
                        dec.dst     = rd;
                        dec.tuse_rs = TUSE_ALU;
                        dec.tuse_rt = TUSE_ALU;
                    end
                    FN_JR: dec.tuse_rs = TUSE_BR;
                    FN_JALR: begin
                        dec.dst     = rd;
                        dec.src     = SRC_PC8;
                        dec.tuse_rs = TUSE_BR;
                    end
                    FN_MFHI, FN_MFLO: begin
                        dec.dst = rd;
                        dec.src = SRC_XALU;
                        dec.md  = 1'b1;
                    end
                    FN_MTHI, FN_MTLO: begin
                        dec.tuse_rs = TUSE_ALU;
                        dec.md      = 1'b1;
                    end
                    FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
                        dec.tuse_rs  = TUSE_ALU;
                        dec.tuse_rt  = TUSE_ALU;
                        dec.md       = 1'b1;
                        dec.md_start = 1'b1;
                        dec.md_div   = (fn == FN_DIV) || (fn == FN_DIVU);
                    end
                    default: ;
                endcase
            end
            OP_BEQ, OP_BNE: begin
                dec.tuse_rs = TUSE_BR;
                dec.tuse_rt = TUSE_BR;
            end
            OP_BLEZ, OP_BGTZ: dec.tuse_rs = TUSE_BR;
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: begin
                dec.dst     = rt;
                dec.tuse_rs = TUSE_ALU;
            end
            OP_LUI: dec.dst = rt;
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
                dec.dst     = rt;
                dec.src     = SRC_LOAD;
                dec.tuse_rs = TUSE_ALU;
            end
            OP_SB, OP_SH, OP_SW: begin
                dec.tuse_rs = TUSE_ALU;
                dec.tuse_rt = TUSE_STORE;
            end
            OP_JAL: begin
                dec.dst = 5'd31;
                dec.src = SRC_PC8;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: tracks E/M/W destination shadows and the mult/div
// busy counter, and produces stall plus D- and E-stage forward selects.
module hazard_ctrl
    import mips_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] IR_D,
    input  logic        flush,
    output logic        stall,
    output logic [2:0]  Forward_RS_D,
    output logic [2:0]  Forward_RT_D,
    output logic [2:0]  Forward_RS_E,
    output logic [2:0]  Forward_RT_E,
    output logic        md_busy
);

    localparam int MD_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W  = $clog2(MD_MAX + 1);

    dec_t dec;

    logic [4:0]       e_dst_q, e_dst_d, e_rs_q, e_rs_d, e_rt_q, e_rt_d;
    src_e             e_src_q, e_src_d;
    logic [1:0]       e_tnew_q, e_tnew_d;
    logic             e_md_start_q, e_md_start_d;
    logic [4:0]       m_dst_q, m_dst_d;
    src_e             m_src_q, m_src_d;
    logic [1:0]       m_tnew_q, m_tnew_d;
    logic [4:0]       w_dst_q, w_dst_d;
    logic [CNT_W-1:0] md_cnt_q, md_cnt_d;

    logic stall_rs, stall_rt, stall_md, stall_raw, bubble;
    logic [2:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;

    hazard_decode u_decode (
        .ir  (IR_D),
        .dec (dec)
    );

    function automatic logic [2:0] fwd_m(input logic [4:0] r, input logic [4:0] mdst,
                                         input logic [1:0] mtnew, input src_e msrc);
        fwd_m = (r != 5'd0 && mdst == r && mtnew == 2'd0) ? fwd_of(msrc) : FWD_NONE;
    endfunction

    assign md_busy = (md_cnt_q != '0);

    always_comb begin
        stall_rs = (dec.rs != 5'd0) &&
                   ((e_dst_q == dec.rs && dec.tuse_rs < e_tnew_q) ||
                    (m_dst_q == dec.rs && dec.tuse_rs < m_tnew_q));
        stall_rt = (dec.rt != 5'd0) &&
                   ((e_dst_q == dec.rt && dec.tuse_rt < e_tnew_q) ||
                    (m_dst_q == dec.rt && dec.tuse_rt < m_tnew_q));
        stall_md  = dec.md && (md_busy || e_md_start_q);
        stall_raw = stall_rs || stall_rt || stall_md;
        bubble    = stall_raw || flush;

        fwd_rs_d = fwd_m(dec.rs, m_dst_q, m_tnew_q, m_src_q);
        fwd_rt_d = fwd_m(dec.rt, m_dst_q, m_tnew_q, m_src_q);

        // M wins over W when both hold the register E is about to read.
        fwd_rs_e = fwd_m(e_rs_q, m_dst_q, m_tnew_q, m_src_q);
        if (fwd_rs_e == FWD_NONE && e_rs_q != 5'd0 && w_dst_q == e_rs_q) fwd_rs_e = FWD_WDATA;
        fwd_rt_e = fwd_m(e_rt_q, m_dst_q, m_tnew_q, m_src_q);
        if (fwd_rt_e == FWD_NONE && e_rt_q != 5'd0 && w_dst_q == e_rt_q) fwd_rt_e = FWD_WDATA;
    end

    always_comb begin
        stall        = stall_raw && !reset;
        Forward_RS_D = reset ? FWD_NONE : fwd_rs_d;
        Forward_RT_D = reset ? FWD_NONE : fwd_rt_d;
        Forward_RS_E = reset ? FWD_NONE : fwd_rs_e;
        Forward_RT_E = reset ? FWD_NONE : fwd_rt_e;
    end

    always_comb begin
        e_dst_d      = '0;
        e_src_d      = SRC_ALU;
        e_tnew_d     = '0;
        e_rs_d       = '0;
        e_rt_d       = '0;
        e_md_start_d = 1'b0;
        if (!bubble) begin
            e_dst_d      = dec.dst;
            e_src_d      = dec.src;
            e_tnew_d     = tnew_of(dec.src);
            e_rs_d       = dec.rs;
            e_rt_d       = dec.rt;
            e_md_start_d = dec.md_start;
        end

        m_dst_d  = e_dst_q;
        m_src_d  = e_src_q;
        m_tnew_d = (e_tnew_q == 2'd0) ? 2'd0 : e_tnew_q - 2'd1;
        w_dst_d  = m_dst_q;

        // Flush only blocks new starts; a running operation keeps counting.
        if (!bubble && dec.md_start)
            md_cnt_d = dec.md_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        else if (md_cnt_q != '0)
            md_cnt_d = md_cnt_q - 1'b1;
        else
            md_cnt_d = md_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e_dst_q      <= '0;
            e_src_q      <= SRC_ALU;
            e_tnew_q     <= '0;
            e_rs_q       <= '0;
            e_rt_q       <= '0;
            e_md_start_q <= 1'b0;
            m_dst_q      <= '0;
            m_src_q      <= SRC_ALU;
            m_tnew_q     <= '0;
            w_dst_q      <= '0;
            md_cnt_q     <= '0;
        end else begin
            e_dst_q      <= e_dst_d;
            e_src_q      <= e_src_d;
            e_tnew_q     <= e_tnew_d;
            e_rs_q       <= e_rs_d;
            e_rt_q       <= e_rt_d;
            e_md_start_q <= e_md_start_d;
            m_dst_q      <= m_dst_d;
            m_src_q      <= m_src_d;
            m_tnew_q     <= m_tnew_d;
            w_dst_q      <= w_dst_d;
            md_cnt_q     <= md_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: load-use, ALU-to-branch, jal link forward,
// mult/div busy interlock, $0 handling, flush bubbles and reset behaviour.
module tb_hazard_ctrl;

    logic        clk;
    logic        reset;
    logic [31:0] IR_D;
    logic        flush;
    logic        stall;
    logic [2:0]  Forward_RS_D, Forward_RT_D, Forward_RS_E, Forward_RT_E;
    logic        md_busy;

    int tests_run    = 0;
    int tests_failed = 0;

    localparam logic [31:0] NOP = 32'h0000_0000;

    hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk          (clk),
        .reset        (reset),
        .IR_D         (IR_D),
        .flush        (flush),
        .stall        (stall),
        .Forward_RS_D (Forward_RS_D),
        .Forward_RT_D (Forward_RT_D),
        .Forward_RS_E (Forward_RS_E),
        .Forward_RT_E (Forward_RT_E),
        .md_busy      (md_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt);
        return {op, rs, rt, 16'h0000};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        flush = 1'b0;
        IR_D  = NOP;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        settle();
        tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL reset_stall got=%0b exp=0", stall); end
        tests_run++; if (md_busy !== 1'b0) begin tests_failed++; $display("FAIL reset_md_busy got=%0b exp=0", md_busy); end
        tests_run++;
        if ({Forward_RS_D, Forward_RT_D, Forward_RS_E, Forward_RT_E} !== 12'h000) begin
            tests_failed++;
            $display("FAIL reset_fwd got=%0d/%0d/%0d/%0d exp=0/0/0/0",
                     Forward_RS_D, Forward_RT_D, Forward_RS_E, Forward_RT_E);
        end
        IR_D = itype(6'h23, 5'd0, 5'd1);
        tick();
        IR_D = itype(6'h04, 5'd1, 5'd2);
        settle();
        tests_run++; if (stall !== 1'b1) begin tests_failed++; $display("FAIL reset_pre_stall got=%0b exp=1", stall); end
        reset = 1'b1;
        settle();
        tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL reset_forces_stall got=%0b exp=0", stall); end
        tick();
        reset = 1'b0;
        settle();
        tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL reset_clears_e got=%0b exp=0", stall); end
    endtask

    task automatic test_load_use();
        do_reset();
        IR_D = itype(6'h23, 5'd0, 5'd1);
        settle();
        tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL lw_first got=%0b exp=0", stall); end
        tick();
        IR_D = itype(6'h04, 5'd1, 5'd2);
        settle();
        tests_run++; if (stall !== 1'b1) begin tests_failed++; $display("FAIL lw_beq_c1 got=%0b exp=1", stall); end
        tick();
        settle();
        tests_run++; if (stall !== 1'b1) begin tests_failed++; $display("FAIL lw_beq_c2 got=%0b exp=1", stall); end
        tick();
        settle();
        tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL lw_beq_c3 got=%0b exp=0", stall); end
        tests_run++; if (Forward_RS_D !== 3'd0) begin tests_failed++; $display("FAIL lw_beq_fwd got=%0d exp=0", Forward_RS_D); end

        // ALU reader of a load stalls once; a store's data operand never stalls.
        do_reset();
        IR_D = itype(6'h23, 5'd0, 5'd1);
        tick();
        IR_D = rtype(5'd1, 5'd0, 5'd6, 6'h21);
        settle();
        tests_run++; if (stall !== 1'b1) begin tests_failed++; $display("FAIL lw_addu_c1 got=%0b exp=1", stall); end
        tick();
        settle();
        tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL lw_addu_c2 got=%0b exp=0", stall); end
        do_reset();
        IR_D = itype(6'h23, 5'd0, 5'd1);
        tick();
        IR_D = itype(6'h2b, 5'd2, 5'd1);
        settle();
        tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL lw_sw got=%0b exp=0", stall); end
    endtask

    task automatic test_alu_jr();
        do_reset();
        IR_D = rtype(5'd1, 5'd2, 5'd3, 6'h21);
        tick();
        IR_D = rtype(5'd3, 5'd0, 5'd0, 6'h08);
        settle();
        tests_run++; if (stall !== 1'b1) begin tests_failed++; $display("FAIL addu_jr_c1 got=%0b exp=1", stall); end
        tick();
        settle();
        tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL addu_jr_c2 got=%0b exp=0", stall); end
        tests_run++; if (Forward_RS_D !== 3'd1) begin tests_failed++; $display("FAIL addu_jr_fwd got=%0d exp=1", Forward_RS_D); end
    endtask

    task automatic test_jal();
        do_reset();
        IR_D = {6'h03, 26'd0};
        tick();
        IR_D = NOP;
        tick();
        IR_D = rtype(5'd31, 5'd0, 5'd0, 6'h08);
        settle();
        tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL jal_jr_stall got=%0b exp=0", stall); end
        tests_run++; if (Forward_RS_D !== 3'd2) begin tests_failed++; $display("FAIL jal_jr_fwd got=%0d exp=2", Forward_RS_D); end
        reset = 1'b1;
        settle();
        tests_run++; if (Forward_RS_D !== 3'd0) begin tests_failed++; $display("FAIL reset_forces_fwd got=%0d exp=0", Forward_RS_D); end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_div_mflo();
        do_reset();
        IR_D = rtype(5'd1, 5'd2, 5'd0, 6'h1a);
        tick();
        IR_D = rtype(5'd0, 5'd0, 5'd4, 6'h12);
        for (int i = 0; i < 10; i++) begin
            settle();
            tests_run++; if (stall !== 1'b1) begin tests_failed++; $display("FAIL div_mflo_stall[%0d] got=%0b exp=1", i, stall); end
            tests_run++; if (md_busy !== 1'b1) begin tests_failed++; $display("FAIL div_busy[%0d] got=%0b exp=1", i, md_busy); end
            tick();
        end
        settle();
        tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL div_release_stall got=%0b exp=0", stall); end
        tests_run++; if (md_busy !== 1'b0) begin tests_failed++; $display("FAIL div_release_busy got=%0b exp=0", md_busy); end
        tick();
        IR_D = NOP;
        tick();
        IR_D = itype(6'h04, 5'd4, 5'd0);
        settle();
        tests_run++; if (Forward_RS_D !== 3'd3) begin tests_failed++; $display("FAIL mflo_beq_fwd got=%0d exp=3", Forward_RS_D); end
    endtask

    task automatic test_mult();
        int stall_cycles;
        do_reset();
        IR_D = rtype(5'd1, 5'd2, 5'd0, 6'h18);
        tick();
        IR_D = rtype(5'd1, 5'd0, 5'd0, 6'h11);
        stall_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            settle();
            if (stall === 1'b1) stall_cycles++;
            tick();
        end
        tests_run++; if (stall_cycles != 5) begin tests_failed++; $display("FAIL mult_mthi_cycles got=%0d exp=5", stall_cycles); end

        // Flush must not cancel a running op; reset must.
        do_reset();
        IR_D = rtype(5'd1, 5'd2, 5'd0, 6'h18);
        tick();
        IR_D  = NOP;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        settle();
        tests_run++; if (md_busy !== 1'b1) begin tests_failed++; $display("FAIL mult_flush_busy got=%0b exp=1", md_busy); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        IR_D = rtype(5'd0, 5'd0, 5'd4, 6'h10);
        settle();
        tests_run++; if (md_busy !== 1'b0) begin tests_failed++; $display("FAIL mult_reset_busy got=%0b exp=0", md_busy); end
        tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL mult_reset_mfhi got=%0b exp=0", stall); end
    endtask

    task automatic test_zero_reg();
        do_reset();
        IR_D = rtype(5'd1, 5'd2, 5'd0, 6'h21);
        tick();
        IR_D = rtype(5'd0, 5'd0, 5'd4, 6'h21);
        settle();
        tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL zero_stall got=%0b exp=0", stall); end
        tick();
        IR_D = rtype(5'd0, 5'd0, 5'd5, 6'h21);
        settle();
        tests_run++;
        if ({Forward_RS_D, Forward_RT_D, Forward_RS_E, Forward_RT_E} !== 12'h000) begin
            tests_failed++;
            $display("FAIL zero_fwd got=%0d/%0d/%0d/%0d exp=0/0/0/0",
                     Forward_RS_D, Forward_RT_D, Forward_RS_E, Forward_RT_E);
        end
        do_reset();
        IR_D = itype(6'h23, 5'd0, 5'd0);
        tick();
        IR_D = itype(6'h04, 5'd0, 5'd0);
        settle();
        tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL zero_load_stall got=%0b exp=0", stall); end
    endtask

    task automatic test_fwd_e();
        do_reset();
        IR_D = rtype(5'd1, 5'd2, 5'd3, 6'h21);
        tick();
        IR_D = rtype(5'd1, 5'd2, 5'd3, 6'h21);
        tick();
        IR_D = rtype(5'd3, 5'd3, 5'd7, 6'h21);
        settle();
        tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL back_to_back_stall got=%0b exp=0", stall); end
        tick();
        IR_D = NOP;
        settle();
        tests_run++; if (Forward_RS_E !== 3'd1) begin tests_failed++; $display("FAIL fwd_e_rs_m got=%0d exp=1", Forward_RS_E); end
        tests_run++; if (Forward_RT_E !== 3'd1) begin tests_failed++; $display("FAIL fwd_e_rt_m got=%0d exp=1", Forward_RT_E); end
        IR_D = rtype(5'd1, 5'd2, 5'd3, 6'h21);
        tick();
        IR_D = NOP;
        tick();
        IR_D = rtype(5'd0, 5'd3, 5'd8, 6'h21);
        tick();
        IR_D = NOP;
        settle();
        tests_run++; if (Forward_RT_E !== 3'd4) begin tests_failed++; $display("FAIL fwd_e_rt_w got=%0d exp=4", Forward_RT_E); end
        tests_run++; if (Forward_RS_E !== 3'd0) begin tests_failed++; $display("FAIL fwd_e_rs_zero got=%0d exp=0", Forward_RS_E); end
    endtask

    task automatic test_flush();
        do_reset();
        IR_D  = itype(6'h23, 5'd0, 5'd5);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        IR_D  = rtype(5'd5, 5'd0, 5'd6, 6'h21);
        settle();
        tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL flush_bubble got=%0b exp=0", stall); end
        do_reset();
        IR_D = itype(6'h23, 5'd0, 5'd5);
        tick();
        IR_D = rtype(5'd5, 5'd0, 5'd6, 6'h21);
        settle();
        tests_run++; if (stall !== 1'b1) begin tests_failed++; $display("FAIL noflush_stall got=%0b exp=1", stall); end
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        IR_D  = NOP;
        test_reset();
        test_load_use();
        test_alu_jr();
        test_jal();
        test_div_mflo();
        test_mult();
        test_zero_reg();
        test_fwd_e();
        test_flush();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
